gpio_bank: RTL

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Bank of NUM_PORTS general purpose inputs. Each pin is synchronized, then
// optionally debounced (sampled on a shared prescaler tick), edge-detected
// according to a per-port edge mode, and latched into sticky pending/overrun
// flags that can raise a single masked interrupt.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   enable       global run enable (prescaler, level, history, flags)
//   div_load     prescaler terminal count; a tick occurs every div_load+1 cycles
//   in_data      asynchronous pin inputs, one per port
//   clr          per-port pulse that clears pending and overrun
//   en_filter    per-port debounce enable
//   irq_mask     per-port interrupt mask (1 = may raise irq)
//   select_edge  two bits per port: 00 none, 01 rising, 10 falling, 11 both
//   out_data     {zero pad, overrun, pending, level}
//   irq          registered OR of pending & irq_mask
//
// DATA_WIDTH must be at least 3*NUM_PORTS; DEBOUNCE_SAMPLES must be 2..16.
// -----------------------------------------------------------------------------
module gpio_bank #(
   parameter int NUM_PORTS        = 12,
   parameter int DATA_WIDTH       = 64,
   parameter int DIV_WIDTH        = 20,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [DIV_WIDTH-1:0]     div_load,
   input  logic [NUM_PORTS-1:0]     in_data,
   input  logic [NUM_PORTS-1:0]     clr,
   input  logic [NUM_PORTS-1:0]     en_filter,
   input  logic [NUM_PORTS-1:0]     irq_mask,
   input  logic [2*NUM_PORTS-1:0]   select_edge,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     irq
);

   logic [NUM_PORTS-1:0]                         r_sync1;
   logic [NUM_PORTS-1:0]                         r_sync2;
   logic [DIV_WIDTH-1:0]                         r_cnt;
   logic [NUM_PORTS-1:0][DEBOUNCE_SAMPLES-2:0]   r_hist;
   logic [NUM_PORTS-1:0]                         r_level;
   logic [NUM_PORTS-1:0]                         r_pending;
   logic [NUM_PORTS-1:0]                         r_overrun;
   logic                                         r_irq;

   logic                                         w_tick;
   logic [NUM_PORTS-1:0][DEBOUNCE_SAMPLES-1:0]   w_window;
   logic [NUM_PORTS-1:0][DEBOUNCE_SAMPLES-2:0]   w_histNext;
   logic [NUM_PORTS-1:0]                         w_levelNext;
   logic [NUM_PORTS-1:0]                         w_event;
   logic [NUM_PORTS-1:0]                         w_pendingNext;
   logic [NUM_PORTS-1:0]                         w_overrunNext;

   // The prescaler ticks on the cycle its count has reached the terminal
   // value, so div_load = 0 gives a tick every enabled cycle.
   assign w_tick = enable & (r_cnt >= div_load);

   // Debounce window per port: the newest synchronized sample followed by the
   // stored history. A level change is accepted only when the whole window
   // agrees, i.e. DEBOUNCE_SAMPLES consecutive ticks saw the same value.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_window
      assign w_window[g] = {r_hist[g], r_sync2[g]};
   end

   // Next level and sample history for every port. Unfiltered ports simply
   // follow the synchronizer while enabled; filtered ports only move on a
   // tick. An event is the level transition qualified by the port's edge
   // mode, evaluated on the same cycle the level register changes.
   always_comb begin
      w_levelNext = r_level;
      w_histNext  = r_hist;
      w_event     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (enable) begin
            if (!en_filter[i]) begin
               w_levelNext[i] = r_sync2[i];
            end else if (w_tick) begin
               w_histNext[i] = w_window[i][DEBOUNCE_SAMPLES-2:0];
               if ((&w_window[i]) && !r_level[i]) begin
                  w_levelNext[i] = 1'b1;
               end else if (!(|w_window[i]) && r_level[i]) begin
                  w_levelNext[i] = 1'b0;
               end
            end
         end
         w_event[i] = (~r_level[i] &  w_levelNext[i] & select_edge[2*i])
                    | ( r_level[i] & ~w_levelNext[i] & select_edge[2*i+1]);
      end
   end

   // Sticky flags. An event always sets pending; it also flags an overrun if
   // pending was already set, unless software is clearing on that very cycle,
   // in which case the event wins for pending and overrun is left alone.
   always_comb begin
      w_pendingNext = r_pending;
      w_overrunNext = r_overrun;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_event[i]) begin
            w_pendingNext[i] = 1'b1;
            if (!clr[i]) begin
               w_overrunNext[i] = r_overrun[i] | r_pending[i];
            end
         end else if (clr[i]) begin
            w_pendingNext[i] = 1'b0;
            w_overrunNext[i] = 1'b0;
         end
      end
   end

   // The synchronizer always runs so the pins are already settled when the
   // bank is enabled; everything else advances only under enable, except the
   // flags, which still honour clr while the bank is stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_cnt     <= '0;
         r_hist    <= '0;
         r_level   <= '0;
         r_pending <= '0;
         r_overrun <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_sync1   <= in_data;
         r_sync2   <= r_sync1;
         if (enable) begin
            r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
         end
         r_hist    <= w_histNext;
         r_level   <= w_levelNext;
         r_pending <= w_pendingNext;
         r_overrun <= w_overrunNext;
         r_irq     <= |(r_pending & irq_mask);
      end
   end

   // Status word: level, pending and overrun packed low, unused bits zero.
   always_comb begin
      out_data = '0;
      out_data[3*NUM_PORTS-1:0] = {r_overrun, r_pending, r_level};
   end

   assign irq = r_irq;

endmodule
